// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: direct-mapped table of 2-bit
// saturating counters, looked up from IF and trained from EX/MEM.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   if_pc/if_inst fetch PC and instruction used for the lookup
//   stall         freezes training and statistics; lookup stays live
//   em_branch     EX/MEM holds a resolved conditional branch
//   em_pc         PC of that branch (selects the entry to train)
//   em_taken      resolved outcome
//   em_guess      guess made for that branch at fetch
//   guess_result  combinational taken/not-taken guess for if_inst
//   mispredict    registered one-cycle pulse after a wrong guess resolves
//   branch_cnt    saturating count of resolved branches
//   miss_cnt      saturating count of mispredicted branches

module branch_predictor #(
    parameter int         INDEX_BITS = 4,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_inst,
    input  logic                 stall,
    input  logic                 em_branch,
    input  logic [31:0]          em_pc,
    input  logic                 em_taken,
    input  logic                 em_guess,
    output logic                 guess_result,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    localparam int         DEPTH     = 1 << INDEX_BITS;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    logic [1:0]            pht [DEPTH];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [1:0]            cur;
    logic [1:0]            nxt;
    logic                  upd;
    logic                  wrong;
    logic                  unused_bits;

    assign rd_idx = if_pc[INDEX_BITS+1:2];
    assign wr_idx = em_pc[INDEX_BITS+1:2];
    assign upd    = em_branch && !stall;
    assign wrong  = em_guess != em_taken;
    assign cur    = pht[wr_idx];

    // Reads the registered table only, so a same-cycle write to the
    // looked-up entry shows up one cycle later.
    assign guess_result = (if_inst[6:2] == OP_BRANCH) && pht[rd_idx][1];

    always_comb begin
        nxt = cur;
        unique case (1'b1)
            em_taken && (cur != 2'b11):  nxt = cur + 2'd1;
            !em_taken && (cur != 2'b00): nxt = cur - 2'd1;
            default:                     nxt = cur;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= INIT_STATE;
            end
        end else if (upd) begin
            pht[wr_idx] <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= upd && wrong;
            if (upd && !(&branch_cnt)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (upd && wrong && !(&miss_cnt)) begin
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign unused_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0],
                           em_pc[31:INDEX_BITS+2], em_pc[1:0],
                           if_inst[31:7], if_inst[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Expected values are hand-derived from the counter encoding.

module tb_branch_predictor;

    localparam logic [31:0] BEQ = 32'h0000_0063;
    localparam logic [31:0] JAL = 32'h0000_006f;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stall;
    logic        em_branch;
    logic [31:0] em_pc;
    logic        em_taken;
    logic        em_guess;
    logic        guess_result;
    logic        mispredict;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int checks;
    int errors;
    int exp_b;
    int exp_m;

    branch_predictor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .stall        (stall),
        .em_branch    (em_branch),
        .em_pc        (em_pc),
        .em_taken     (em_taken),
        .em_guess     (em_guess),
        .guess_result (guess_result),
        .mispredict   (mispredict),
        .branch_cnt   (branch_cnt),
        .miss_cnt     (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One unstalled resolve; also advances the statistics model.
    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic gs);
        em_branch = 1'b1;
        em_pc     = pc;
        em_taken  = tk;
        em_guess  = gs;
        stall     = 1'b0;
        tick();
        em_branch = 1'b0;
        if (exp_b < 16'hffff) exp_b++;
        if (gs != tk && exp_m < 16'hffff) exp_m++;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        if_pc   = pc;
        if_inst = inst;
        #1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_bcnt"}, 32'(branch_cnt), 32'(exp_b));
        chk({tag, "_mcnt"}, 32'(miss_cnt), 32'(exp_m));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_b     = 0;
        exp_m     = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        em_branch = 1'b0;
        em_pc     = '0;
        em_taken  = 1'b0;
        em_guess  = 1'b0;
        if_pc     = 32'h40;
        if_inst   = BEQ;
        #12;
        chk("rst_guess", 32'(guess_result), 0);
        chk("rst_misp", 32'(mispredict), 0);
        #10 rst_n = 1'b1;
        tick();

        // 1 reset state
        fetch(32'h40, BEQ);
        chk("t1_guess", 32'(guess_result), 0);
        chk_stats("t1");

        // 2 training on index 0
        resolve(32'h40, 1'b1, 1'b0);
        chk("t2_misp_a", 32'(mispredict), 1);
        resolve(32'h40, 1'b1, 1'b1);
        chk("t2_misp_b", 32'(mispredict), 0);
        fetch(32'h40, BEQ);
        chk("t2_strong_t", 32'(guess_result), 1);
        resolve(32'h40, 1'b0, 1'b1);
        fetch(32'h40, BEQ);
        chk("t2_weak_t", 32'(guess_result), 1);
        resolve(32'h40, 1'b0, 1'b0);
        fetch(32'h40, BEQ);
        chk("t2_weak_nt", 32'(guess_result), 0);
        chk_stats("t2");
        tick();
        chk("t2_misp_idle", 32'(mispredict), 0);

        // 3 counter saturation on index 1
        for (int i = 0; i < 5; i++) resolve(32'h44, 1'b1, 1'b1);
        fetch(32'h44, BEQ);
        chk("t3_sat_t", 32'(guess_result), 1);
        resolve(32'h44, 1'b0, 1'b1);
        fetch(32'h44, BEQ);
        chk("t3_after_st", 32'(guess_result), 1);
        for (int i = 0; i < 5; i++) resolve(32'h44, 1'b0, 1'b0);
        fetch(32'h44, BEQ);
        chk("t3_sat_nt", 32'(guess_result), 0);
        resolve(32'h44, 1'b1, 1'b0);
        fetch(32'h44, BEQ);
        chk("t3_after_snt", 32'(guess_result), 0);
        resolve(32'h44, 1'b1, 1'b0);
        fetch(32'h44, BEQ);
        chk("t3_back_wt", 32'(guess_result), 1);
        chk_stats("t3");

        // 4 collision: index 0 holds 01
        fetch(32'h80, BEQ);
        em_branch = 1'b1;
        em_pc     = 32'h80;
        em_taken  = 1'b1;
        em_guess  = 1'b0;
        #1;
        chk("t4_same_cyc", 32'(guess_result), 0);
        tick();
        em_branch = 1'b0;
        exp_b++;
        exp_m++;
        #1;
        chk("t4_next_cyc", 32'(guess_result), 1);

        // 5 stall on index 2, wrong guess
        tick();
        fetch(32'h80, BEQ);
        em_branch = 1'b1;
        em_pc     = 32'h48;
        em_taken  = 1'b0;
        em_guess  = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_misp", 32'(mispredict), 0);
            chk_stats("t5_stall");
            chk("t5_live_look", 32'(guess_result), 1);
        end
        stall = 1'b0;
        tick();
        em_branch = 1'b0;
        exp_b++;
        exp_m++;
        chk("t5_misp_pulse", 32'(mispredict), 1);
        chk_stats("t5_once");
        tick();
        chk("t5_misp_drop", 32'(mispredict), 0);
        chk_stats("t5_after");

        // 6 JAL ignored, aliasing 0x40/0x80
        fetch(32'h40, JAL);
        chk("t6_jal", 32'(guess_result), 0);
        resolve(32'h40, 1'b1, 1'b1);
        resolve(32'h40, 1'b1, 1'b1);
        fetch(32'h80, BEQ);
        chk("t6_alias", 32'(guess_result), 1);
        fetch(32'h44, BEQ);
        chk("t6_idx1", 32'(guess_result), 1);

        // reset in the middle of an update
        em_branch = 1'b1;
        em_pc     = 32'h44;
        em_taken  = 1'b1;
        em_guess  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_guess", 32'(guess_result), 0);
        tick();
        em_branch = 1'b0;
        #3 rst_n = 1'b1;
        exp_b = 0;
        exp_m = 0;
        tick();
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), BEQ);
            chk($sformatf("rst_entry%0d", i), 32'(guess_result), 0);
        end
        chk_stats("rst_mid");
        chk("rst_mid_misp", 32'(mispredict), 0);
        resolve(32'h40, 1'b1, 1'b1);
        resolve(32'h44, 1'b1, 1'b1);
        fetch(32'h40, BEQ);
        chk("rst_e0_weak", 32'(guess_result), 1);
        fetch(32'h44, BEQ);
        chk("rst_e1_weak", 32'(guess_result), 1);

        // 3b statistics counter saturation
        while (exp_m < 16'hffff) resolve(32'hc0, 1'b0, 1'b1);
        chk_stats("sat_reach");
        resolve(32'hc0, 1'b1, 1'b0);
        chk("sat_bcnt_hold", 32'(branch_cnt), 32'hffff);
        chk("sat_mcnt_hold", 32'(miss_cnt), 32'hffff);
        chk("sat_misp", 32'(mispredict), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
